// File: rtl/blink_pkg.sv
// Shared constants and state encodings for the UART command receiver
// that configures the LED blinker.
package blink_pkg;

  localparam logic [7:0] OP_MASK = 8'h4D;
  localparam logic [7:0] OP_RATE = 8'h52;
  localparam logic [7:0] OP_EN   = 8'h45;

  typedef enum logic [0:0] {
    P_CMD,
    P_ARG
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Integer divide; the receiver needs at least 4 clocks per bit.
  function automatic int clksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  function automatic logic isOpcode(input logic [7:0] b);
    return (b == OP_MASK) || (b == OP_RATE) || (b == OP_EN);
  endfunction

endpackage

// File: rtl/blink_cmd_rx_if.sv
// Serial input plus the blinker configuration outputs of blink_cmd_rx.
// The slave side is the receiver; the master side is whoever drives rx.
interface blink_cmd_rx_if;
  logic        rx;
  logic [31:0] half_period;
  logic [7:0]  led_mask;
  logic        enable;
  logic        cmd_done;
  logic        cmd_err;

  modport master (
    output rx,
    input  half_period, led_mask, enable, cmd_done, cmd_err
  );

  modport slave (
    input  rx,
    output half_period, led_mask, enable, cmd_done, cmd_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect,
// mid-bit sampling, registered byte/valid/framing-error outputs.
module uart_rx
  import blink_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rxByte_o,
  output logic       byteValid_o,
  output logic       frameErr_o
);

  localparam int CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e       state_q;
  logic            rxMeta_q;
  logic            rxSync_q;
  logic            rxPrev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bitIdx_q;
  logic [7:0]      shift_q;
  logic            byteValid_q;
  logic            frameErr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q    <= 1'b1;
      rxSync_q    <= 1'b1;
      rxPrev_q    <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      rxMeta_q    <= rx_i;
      rxSync_q    <= rxMeta_q;
      rxPrev_q    <= rxSync_q;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          // Only a genuine 1->0 transition starts a frame, never a held-low line.
          if (rxPrev_q && !rxSync_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HalfMax) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == BitMax) begin
            cnt_q    <= '0;
            shift_q  <= {rxSync_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == BitMax) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rxSync_q) byteValid_q <= 1'b1;
            else          frameErr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rxByte_o    = shift_q;
  assign byteValid_o = byteValid_q;
  assign frameErr_o  = frameErr_q;

endmodule

// File: rtl/blink_cmd_rx.sv
// Decodes two-byte UART commands (opcode, argument) into the blinker's
// rate, LED mask and run/stop registers.
module blink_cmd_rx
  import blink_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_CLKS = CLK_FREQ / 100
) (
  input logic           clk,
  input logic           rst,
  blink_cmd_rx_if.slave bus
);

  localparam logic [31:0] HalfPeriodRst = 32'(CLK_FREQ / 4);
  localparam logic [31:0] RateUnit      = 32'(CLK_FREQ / 100);
  localparam logic [31:0] TimeoutMax    = 32'(TIMEOUT_CLKS);

  logic [7:0] rxByte;
  logic       byteValid;
  logic       frameErr;

  uart_rx #(
    .CLKS_PER_BIT(clksPerBit(CLK_FREQ, BAUD))
  ) u_uart_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (bus.rx),
    .rxByte_o   (rxByte),
    .byteValid_o(byteValid),
    .frameErr_o (frameErr)
  );

  parse_state_e state_q;
  logic [7:0]   opcode_q;
  logic [31:0]  timeout_q;
  logic [31:0]  halfPeriod_q;
  logic [7:0]   ledMask_q;
  logic         enable_q;
  logic         cmdDone_q;
  logic         cmdErr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= P_CMD;
      opcode_q     <= '0;
      timeout_q    <= '0;
      halfPeriod_q <= HalfPeriodRst;
      ledMask_q    <= 8'hFF;
      enable_q     <= 1'b1;
      cmdDone_q    <= 1'b0;
      cmdErr_q     <= 1'b0;
    end else begin
      cmdDone_q <= 1'b0;
      cmdErr_q  <= 1'b0;
      if (frameErr) begin
        cmdErr_q <= 1'b1;
        state_q  <= P_CMD;
      end else begin
        case (state_q)
          P_CMD: begin
            if (byteValid) begin
              if (isOpcode(rxByte)) begin
                opcode_q  <= rxByte;
                timeout_q <= '0;
                state_q   <= P_ARG;
              end else begin
                cmdErr_q <= 1'b1;
              end
            end
          end
          P_ARG: begin
            // An arriving byte outranks a timeout expiring in the same cycle.
            if (byteValid) begin
              case (opcode_q)
                OP_MASK: ledMask_q    <= rxByte;
                OP_RATE: halfPeriod_q <= ({24'd0, rxByte} + 32'd1) * RateUnit;
                OP_EN:   enable_q     <= rxByte[0];
                default: ;
              endcase
              cmdDone_q <= 1'b1;
              state_q   <= P_CMD;
            end else if (timeout_q == TimeoutMax) begin
              cmdErr_q <= 1'b1;
              state_q  <= P_CMD;
            end else begin
              timeout_q <= timeout_q + 32'd1;
            end
          end
          default: state_q <= P_CMD;
        endcase
      end
    end
  end

  assign bus.half_period = halfPeriod_q;
  assign bus.led_mask    = ledMask_q;
  assign bus.enable      = enable_q;
  assign bus.cmd_done    = cmdDone_q;
  assign bus.cmd_err     = cmdErr_q;

endmodule

// File: tb/tb_blink_cmd_rx.sv
// Directed bench for blink_cmd_rx: every cmd_done/cmd_err pulse is matched
// against a queue of expected events carrying the register values due then.
module tb_blink_cmd_rx;

  localparam int ClkFreq     = 1_000_000;
  localparam int Baud        = 100_000;
  localparam int TimeoutClks = 10_000;
  localparam int Cpb         = ClkFreq / Baud;

  typedef struct packed {
    logic        isErr;
    logic [31:0] halfPeriod;
    logic [7:0]  ledMask;
    logic        enable;
  } event_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  blink_cmd_rx_if bif ();

  blink_cmd_rx #(
    .CLK_FREQ    (ClkFreq),
    .BAUD        (Baud),
    .TIMEOUT_CLKS(TimeoutClks)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  event_t      expQ[$];
  event_t      obsEvt;
  event_t      expEvt;
  logic [31:0] expHalf;
  logic [7:0]  expMask;
  logic        expEn;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one 8N1 frame starting at a negedge; returns at the end of the stop bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    bif.rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bif.rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    bif.rx = stopBit;
    repeat (Cpb) @(negedge clk);
    bif.rx = 1'b1;
  endtask

  task automatic pushExp(input logic isErr);
    expQ.push_back('{isErr, expHalf, expMask, expEn});
  endtask

  initial begin
    bif.rx  = 1'b1;
    expHalf = 32'd250_000;
    expMask = 8'hFF;
    expEn   = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (bif.cmd_done || bif.cmd_err) begin
          checkOutput("pulse_exclusive", 64'(bif.cmd_done & bif.cmd_err), 64'd0);
          checkOutput("pulse_expected", 64'(expQ.size() != 0), 64'd1);
          if (expQ.size() != 0) begin
            obsEvt = '{bif.cmd_err, bif.half_period, bif.led_mask, bif.enable};
            expEvt = expQ.pop_front();
            checkOutput("pulse_event", 64'(obsEvt), 64'(expEvt));
          end
        end
      end
    join_none

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("reset_half_period", 64'(bif.half_period), 64'(expHalf));
    checkOutput("reset_led_mask", 64'(bif.led_mask), 64'(expMask));
    checkOutput("reset_enable", 64'(bif.enable), 64'(expEn));
    checkOutput("reset_cmd_done", 64'(bif.cmd_done), 64'd0);
    checkOutput("reset_cmd_err", 64'(bif.cmd_err), 64'd0);

    expMask = 8'h3C;
    pushExp(1'b0);
    applyStimulus(8'h4D, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("mask_3c_drained", 64'(expQ.size()), 64'd0);
    checkOutput("mask_3c", 64'(bif.led_mask), 64'(expMask));

    expHalf = 32'd50_000;
    pushExp(1'b0);
    applyStimulus(8'h52, 1'b1);
    applyStimulus(8'h04, 1'b1);
    expEn = 1'b0;
    pushExp(1'b0);
    applyStimulus(8'h45, 1'b1);
    applyStimulus(8'hFE, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("rate_en_drained", 64'(expQ.size()), 64'd0);
    checkOutput("rate_50000", 64'(bif.half_period), 64'(expHalf));
    checkOutput("enable_off", 64'(bif.enable), 64'(expEn));

    pushExp(1'b1);
    applyStimulus(8'h41, 1'b1);
    expMask = 8'h01;
    pushExp(1'b0);
    applyStimulus(8'h4D, 1'b1);
    applyStimulus(8'h01, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("bad_op_drained", 64'(expQ.size()), 64'd0);
    checkOutput("mask_01", 64'(bif.led_mask), 64'(expMask));

    // Timeout: one error when the argument never arrives, one for 0x07 as an opcode.
    pushExp(1'b1);
    pushExp(1'b1);
    applyStimulus(8'h52, 1'b1);
    repeat (TimeoutClks - 50) @(negedge clk);
    checkOutput("timeout_not_early", 64'(expQ.size()), 64'd2);
    repeat (100) @(negedge clk);
    checkOutput("timeout_fired", 64'(expQ.size()), 64'd1);
    applyStimulus(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("timeout_drained", 64'(expQ.size()), 64'd0);
    checkOutput("timeout_rate_kept", 64'(bif.half_period), 64'(expHalf));

    pushExp(1'b1);
    applyStimulus(8'h4D, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("frame_err_drained", 64'(expQ.size()), 64'd0);
    checkOutput("frame_err_mask_kept", 64'(bif.led_mask), 64'(expMask));

    bif.rx = 1'b0;
    repeat (3) @(negedge clk);
    bif.rx = 1'b1;
    repeat (150) @(negedge clk);
    checkOutput("glitch_no_pulse", 64'(expQ.size()), 64'd0);
    expMask = 8'hAA;
    pushExp(1'b0);
    applyStimulus(8'h4D, 1'b1);
    applyStimulus(8'hAA, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("after_glitch_drained", 64'(expQ.size()), 64'd0);
    checkOutput("after_glitch_mask", 64'(bif.led_mask), 64'(expMask));

    // Reset while the parser waits for an argument and a byte is mid-flight.
    applyStimulus(8'h52, 1'b1);
    bif.rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    bif.rx = 1'b1;
    repeat (25) @(negedge clk);
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    expHalf = 32'd250_000;
    expMask = 8'hFF;
    expEn   = 1'b1;
    repeat (150) @(negedge clk);
    checkOutput("rst_mid_half_period", 64'(bif.half_period), 64'(expHalf));
    checkOutput("rst_mid_led_mask", 64'(bif.led_mask), 64'(expMask));
    checkOutput("rst_mid_enable", 64'(bif.enable), 64'(expEn));
    checkOutput("rst_mid_no_pulse", 64'(expQ.size()), 64'd0);
    expEn = 1'b0;
    pushExp(1'b0);
    applyStimulus(8'h45, 1'b1);
    applyStimulus(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("after_rst_drained", 64'(expQ.size()), 64'd0);
    checkOutput("after_rst_enable", 64'(bif.enable), 64'(expEn));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
